// File: rtl/n1_pbus_arb.sv
// Two-initiator arbiter for the N1 pipelined Wishbone program bus.
// Define N1_PBUS_ARB_RR_EN for round-robin; default is fixed priority (port 0).
module n1_pbus_arb #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 pbus0_cyc_i,
    input  logic                 pbus0_stb_i,
    input  logic                 pbus0_we_i,
    input  logic [ADR_WIDTH-1:0] pbus0_adr_i,
    input  logic [DAT_WIDTH-1:0] pbus0_dat_i,
    output logic                 pbus0_ack_o,
    output logic                 pbus0_err_o,
    output logic                 pbus0_rty_o,
    output logic                 pbus0_stall_o,
    output logic [DAT_WIDTH-1:0] pbus0_dat_o,
    input  logic                 pbus1_cyc_i,
    input  logic                 pbus1_stb_i,
    input  logic                 pbus1_we_i,
    input  logic [ADR_WIDTH-1:0] pbus1_adr_i,
    input  logic [DAT_WIDTH-1:0] pbus1_dat_i,
    output logic                 pbus1_ack_o,
    output logic                 pbus1_err_o,
    output logic                 pbus1_rty_o,
    output logic                 pbus1_stall_o,
    output logic [DAT_WIDTH-1:0] pbus1_dat_o,
    output logic                 pbus_cyc_o,
    output logic                 pbus_stb_o,
    output logic                 pbus_we_o,
    output logic [ADR_WIDTH-1:0] pbus_adr_o,
    output logic [DAT_WIDTH-1:0] pbus_dat_o,
    input  logic                 pbus_ack_i,
    input  logic                 pbus_err_i,
    input  logic                 pbus_rty_i,
    input  logic                 pbus_stall_i,
    input  logic [DAT_WIDTH-1:0] pbus_dat_i,
    output logic [1:0]           prb_arb_state_o,
    output logic [3:0]           prb_arb_outst_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    state_t     state_q, state_d;
    logic [3:0] outst_q, outst_d;
    logic       full;
    logic       rsp_ok;
    logic       rsp;
    logic       accept;
    logic       abort;
    logic       pick1;

`ifdef N1_PBUS_ARB_RR_EN
    // last_q = 1 means port 1 was the most recent owner
    logic last_q, last_d;
    assign pick1 = ~last_q;
`else
    assign pick1 = 1'b0;
`endif

    assign full   = (outst_q == MAX_CNT);
    assign rsp_ok = (state_q != IDLE) && (outst_q != 4'd0);
    assign rsp    = rsp_ok & (pbus_ack_i | pbus_err_i | pbus_rty_i);
    assign accept = pbus_stb_o & ~pbus_stall_i;
    assign abort  = ((state_q == GNT0) && !pbus0_cyc_i) ||
                    ((state_q == GNT1) && !pbus1_cyc_i);

    assign pbus0_dat_o     = pbus_dat_i;
    assign pbus1_dat_o     = pbus_dat_i;
    assign prb_arb_state_o = state_q;
    assign prb_arb_outst_o = outst_q;

    always_comb begin
        state_d       = state_q;
`ifdef N1_PBUS_ARB_RR_EN
        last_d        = last_q;
`endif
        pbus_cyc_o    = 1'b0;
        pbus_stb_o    = 1'b0;
        pbus_we_o     = 1'b0;
        pbus_adr_o    = '0;
        pbus_dat_o    = '0;
        pbus0_stall_o = 1'b1;
        pbus1_stall_o = 1'b1;
        pbus0_ack_o   = 1'b0;
        pbus0_err_o   = 1'b0;
        pbus0_rty_o   = 1'b0;
        pbus1_ack_o   = 1'b0;
        pbus1_err_o   = 1'b0;
        pbus1_rty_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pbus0_cyc_i && pbus1_cyc_i) begin
                    state_d = pick1 ? GNT1 : GNT0;
                end else if (pbus0_cyc_i) begin
                    state_d = GNT0;
                end else if (pbus1_cyc_i) begin
                    state_d = GNT1;
                end
`ifdef N1_PBUS_ARB_RR_EN
                if (pbus0_cyc_i || pbus1_cyc_i)
                    last_d = (state_d == GNT1);
`endif
            end
            GNT0: begin
                pbus_cyc_o    = pbus0_cyc_i;
                pbus_stb_o    = pbus0_stb_i & ~full;
                pbus_we_o     = pbus0_we_i;
                pbus_adr_o    = pbus0_adr_i;
                pbus_dat_o    = pbus0_dat_i;
                pbus0_stall_o = pbus_stall_i | full;
                pbus0_ack_o   = rsp_ok & pbus_ack_i;
                pbus0_err_o   = rsp_ok & pbus_err_i;
                pbus0_rty_o   = rsp_ok & pbus_rty_i;
                if (!pbus0_cyc_i)
                    state_d = IDLE;
            end
            GNT1: begin
                pbus_cyc_o    = pbus1_cyc_i;
                pbus_stb_o    = pbus1_stb_i & ~full;
                pbus_we_o     = pbus1_we_i;
                pbus_adr_o    = pbus1_adr_i;
                pbus_dat_o    = pbus1_dat_i;
                pbus1_stall_o = pbus_stall_i | full;
                pbus1_ack_o   = rsp_ok & pbus_ack_i;
                pbus1_err_o   = rsp_ok & pbus_err_i;
                pbus1_rty_o   = rsp_ok & pbus_rty_i;
                if (!pbus1_cyc_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Abandoned requests are forgotten once the owner drops its cycle
    always_comb begin
        outst_d = outst_q;
        if (abort)
            outst_d = 4'd0;
        else if (accept && !rsp)
            outst_d = outst_q + 4'd1;
        else if (!accept && rsp)
            outst_d = outst_q - 4'd1;
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q <= IDLE;
            outst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
        end
    end

`ifdef N1_PBUS_ARB_RR_EN
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_n1_pbus_arb.sv
// Self-checking bench for n1_pbus_arb: table of per-cycle vectors checked
// through an expected-value queue, plus hand-written reset/data checks.
module tb_n1_pbus_arb;

    localparam logic [15:0] ADR0 = 16'h0100;
    localparam logic [15:0] ADR1 = 16'h0200;
    localparam logic [15:0] WD0  = 16'hA5A5;
    localparam logic [15:0] WD1  = 16'h5A5A;
    localparam logic [15:0] RD   = 16'hC3C3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc0 = 0, stb0 = 0, cyc1 = 0, stb1 = 0;
    logic        ack_i = 0, err_i = 0, rty_i = 0, stall_i = 0;
    logic        ack0, err0, rty0, stall0, ack1, err1, rty1, stall1;
    logic [15:0] rd0, rd1, adr_o, wd_o;
    logic        cyc_o, stb_o, we_o;
    logic [1:0]  st_o;
    logic [3:0]  os_o;
    logic [48:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] in;
        logic [1:0] st;
        logic [3:0] os;
        logic [9:0] fl;
    } vec_t;

    vec_t        tbl[$];
    logic [48:0] sb[$];

    always #5 clk = ~clk;

    n1_pbus_arb dut (
        .clk_i(clk), .async_rst_i(rst_n),
        .pbus0_cyc_i(cyc0), .pbus0_stb_i(stb0), .pbus0_we_i(1'b0),
        .pbus0_adr_i(ADR0), .pbus0_dat_i(WD0),
        .pbus0_ack_o(ack0), .pbus0_err_o(err0), .pbus0_rty_o(rty0),
        .pbus0_stall_o(stall0), .pbus0_dat_o(rd0),
        .pbus1_cyc_i(cyc1), .pbus1_stb_i(stb1), .pbus1_we_i(1'b1),
        .pbus1_adr_i(ADR1), .pbus1_dat_i(WD1),
        .pbus1_ack_o(ack1), .pbus1_err_o(err1), .pbus1_rty_o(rty1),
        .pbus1_stall_o(stall1), .pbus1_dat_o(rd1),
        .pbus_cyc_o(cyc_o), .pbus_stb_o(stb_o), .pbus_we_o(we_o),
        .pbus_adr_o(adr_o), .pbus_dat_o(wd_o),
        .pbus_ack_i(ack_i), .pbus_err_i(err_i), .pbus_rty_i(rty_i),
        .pbus_stall_i(stall_i), .pbus_dat_i(RD),
        .prb_arb_state_o(st_o), .prb_arb_outst_o(os_o)
    );

    assign obs = {st_o, os_o, cyc_o, stb_o, we_o, stall0, stall1,
                  ack0, ack1, err0, err1, rty0, rty1, adr_o, wd_o};

    // Flags: {cyc,stb,stall0,stall1,ack0,ack1,err0,err1,rty0,rty1}
    function automatic logic [48:0] expect_obs(input logic [1:0] st,
                                               input logic [3:0] os,
                                               input logic [9:0] fl);
        logic [15:0] a, d;
        a = (st == 2'd1) ? ADR0 : (st == 2'd2) ? ADR1 : 16'h0;
        d = (st == 2'd1) ? WD0  : (st == 2'd2) ? WD1  : 16'h0;
        return {st, os, fl[9], fl[8], (st == 2'd2), fl[7:0], a, d};
    endfunction

    task automatic add(input logic [7:0] in, input int st,
                       input int os, input logic [9:0] fl);
        vec_t v;
        v.in = in;
        v.st = 2'(st);
        v.os = 4'(os);
        v.fl = fl;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [48:0] act,
                       input logic [48:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // single fetch
        add(8'b1100_0000, 0, 0, 10'b00_11_000000);
        add(8'b1100_0000, 1, 0, 10'b11_01_000000);
        add(8'b1000_1000, 1, 1, 10'b10_01_100000);
        add(8'b0000_0000, 1, 0, 10'b00_01_000000);
        add(8'b0000_0000, 0, 0, 10'b00_11_000000);
        // pipelined burst, target stall, throttle at depth 4
        add(8'b1100_0000, 0, 0, 10'b00_11_000000);
        add(8'b1100_0000, 1, 0, 10'b11_01_000000);
        add(8'b1100_0001, 1, 1, 10'b11_11_000000);
        add(8'b1100_0000, 1, 1, 10'b11_01_000000);
        add(8'b1100_0000, 1, 2, 10'b11_01_000000);
        add(8'b1100_0000, 1, 3, 10'b11_01_000000);
        add(8'b1100_0000, 1, 4, 10'b10_11_000000);
        add(8'b1100_1000, 1, 4, 10'b10_11_100000);
        add(8'b1100_0000, 1, 3, 10'b11_01_000000);
        add(8'b1100_1000, 1, 4, 10'b10_11_100000);
        add(8'b1100_1000, 1, 3, 10'b11_01_100000);
        add(8'b1000_1000, 1, 3, 10'b10_01_100000);
        add(8'b1000_1000, 1, 2, 10'b10_01_100000);
        add(8'b1000_1000, 1, 1, 10'b10_01_100000);
        add(8'b1000_1000, 1, 0, 10'b10_01_000000);
        add(8'b0000_0000, 1, 0, 10'b00_01_000000);
        add(8'b0000_0000, 0, 0, 10'b00_11_000000);
        // port 1: err, rty, then abort with late ack
        add(8'b0011_0000, 0, 0, 10'b00_11_000000);
        add(8'b0011_0000, 2, 0, 10'b11_10_000000);
        add(8'b0011_0000, 2, 1, 10'b11_10_000000);
        add(8'b0010_0100, 2, 2, 10'b10_10_000100);
        add(8'b0010_0010, 2, 1, 10'b10_10_000001);
        add(8'b0011_0000, 2, 0, 10'b11_10_000000);
        add(8'b0011_0000, 2, 1, 10'b11_10_000000);
        add(8'b0000_0000, 2, 2, 10'b00_10_000000);
        add(8'b0000_1000, 0, 0, 10'b00_11_000000);
        add(8'b0000_0000, 0, 0, 10'b00_11_000000);
        // contention
        add(8'b1111_0000, 0, 0, 10'b00_11_000000);
        add(8'b1010_0000, 1, 0, 10'b10_01_000000);
        add(8'b0010_0000, 1, 0, 10'b00_01_000000);
        add(8'b1010_0000, 0, 0, 10'b00_11_000000);
`ifdef N1_PBUS_ARB_RR_EN
        add(8'b1010_0000, 2, 0, 10'b10_10_000000);
        add(8'b0000_0000, 2, 0, 10'b00_10_000000);
`else
        add(8'b1010_0000, 1, 0, 10'b10_01_000000);
        add(8'b0000_0000, 1, 0, 10'b00_01_000000);
`endif
        add(8'b0000_0000, 0, 0, 10'b00_11_000000);

        #2;
        chk("reset_state", obs, expect_obs(2'd0, 4'd0, 10'b00_11_000000));
        #10 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            {cyc0, stb0, cyc1, stb1, ack_i, err_i, rty_i, stall_i} = tbl[i].in;
            sb.push_back(expect_obs(tbl[i].st, tbl[i].os, tbl[i].fl));
            @(negedge clk);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL vec%0d: scoreboard empty", i);
            end else begin
                chk($sformatf("vec%0d", i), obs, sb.pop_front());
            end
        end

        n_tests++;
        if (rd0 !== RD || rd1 !== RD) begin
            n_fail++;
            $display("FAIL rdata_bcast: got %h/%h expected %h", rd0, rd1, RD);
        end

        // asynchronous reset in the middle of a burst
        @(posedge clk);
        #1;
        {cyc0, stb0, cyc1, stb1, ack_i, err_i, rty_i, stall_i} = 8'b1100_0000;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (os_o !== 4'd3) begin
            n_fail++;
            $display("FAIL pre_reset_outst: got %0d expected 3", os_o);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", obs, expect_obs(2'd0, 4'd0, 10'b00_11_000000));
        {cyc0, stb0} = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset", obs, expect_obs(2'd0, 4'd0, 10'b00_11_000000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/n1_pbus_arb.md
# n1_pbus_arb

Two-initiator arbiter for the N1 program bus, a pipelined Wishbone interface. Port 0 carries the flow-control instruction-fetch and memory-I/O master. Port 1 carries a secondary master (debug or DMA). The block grants one port at a time, holds the grant for the owner's whole bus cycle, and tracks outstanding pipelined requests so responses return to the correct port. It throttles issue at a configurable depth. It sits between the N1 core's program-bus master and the single shared program-memory target.

## Interface
Parameters:
- ADR_WIDTH, 16, address width.
- DAT_WIDTH, 16, data width.
- MAX_OUTST, 4, maximum accepted-but-unanswered requests (1..15).

Ports:
- clk_i  in  1  module clock.
- async_rst_i  in  1  reset, asynchronous, active-low.
- pbus0_cyc_i / pbus1_cyc_i  in  1  bus cycle indicator, initiator n.
- pbus0_stb_i / pbus1_stb_i  in  1  access request.
- pbus0_we_i / pbus1_we_i  in  1  write enable.
- pbus0_adr_i / pbus1_adr_i  in  ADR_WIDTH  address.
- pbus0_dat_i / pbus1_dat_i  in  DAT_WIDTH  write data.
- pbus0_ack_o / pbus1_ack_o  out  1  acknowledge to initiator n.
- pbus0_err_o / pbus1_err_o  out  1  error to initiator n.
- pbus0_rty_o / pbus1_rty_o  out  1  retry to initiator n.
- pbus0_stall_o / pbus1_stall_o  out  1  stall to initiator n.
- pbus0_dat_o / pbus1_dat_o  out  DAT_WIDTH  read data (target data broadcast to both).
- pbus_cyc_o, pbus_stb_o, pbus_we_o  out  1  target-side controls.
- pbus_adr_o  out  ADR_WIDTH  target address.
- pbus_dat_o  out  DAT_WIDTH  target write data.
- pbus_ack_i, pbus_err_i, pbus_rty_i, pbus_stall_i  in  1  target responses.
- pbus_dat_i  in  DAT_WIDTH  target read data.
- prb_arb_state_o  out  2  state (0 IDLE, 1 GNT0, 2 GNT1).
- prb_arb_outst_o  out  4  outstanding-request count.

## Operation
State machine (registered):
- IDLE: no owner. pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_adr_o and pbus_dat_o are 0. Both stall_o are 1. All ack/err/rty outputs are 0.
- IDLE -> GNT0 or GNT1 when a cyc_i is high. A single requester wins. On contention, the arbitration policy in Configuration decides.
- GNTn: target controls are muxed combinationally from port n.
  - pbus_stb_o = pbusn_stb_i & (outst != MAX_OUTST).
  - pbusn_stall_o = pbus_stall_i | (outst == MAX_OUTST).
  - The other port sees stall=1 and ack/err/rty=0.
- GNTn -> IDLE when pbusn_cyc_i is low. pbus_cyc_o follows the owner's cyc_i combinationally, so it falls in the same cycle. IDLE is always visited for at least one cycle between owners.

Outstanding counter (outst):
- +1 on accept (pbus_stb_o & ~pbus_stall_i).
- -1 on any of pbus_ack_i, pbus_err_i, pbus_rty_i.
- Accept and response in the same cycle leave outst unchanged.
- The full compare uses the registered count, so a same-cycle response never enables an extra accept.
- Never wraps: a response with outst==0 is dropped and not forwarded. Increment is impossible at MAX_OUTST.

Response routing: ack/err/rty go only to the owner, and only in GNTn.

Abort: when the owner drops cyc with outst>0, outst clears to 0 on the next edge. Late target responses arriving in IDLE are discarded.

Reset: async_rst_i low forces IDLE and outst=0 immediately; outputs take their IDLE values. Any in-flight transfer is abandoned without a response.

## Timing
- Grant latency: cyc_i rising in IDLE in cycle t gives pbus_cyc_o=1 in cycle t+1. A stb_i presented in cycle t is forwarded in t+1.
- Within a grant, request-to-target and response-to-initiator paths are combinational: zero added latency.
- Release: owner cyc low in cycle t -> IDLE in t+1 -> the other port can be granted no earlier than t+2.
- Throughput: one accept per cycle while outst < MAX_OUTST and target not stalling.

## Configuration
- N1_PBUS_ARB_RR_EN defined: round-robin. A last-owner flag is updated on each grant. On contention, the port not granted last wins. The flag resets to 1, so port 0 wins the first contention.
- N1_PBUS_ARB_RR_EN undefined: fixed priority. Port 0 always wins contention. No last-owner register is built.

## Test plan
- Single fetch: port 0 cyc/stb with adr=0x0100, target ack one cycle later -> pbus_adr_o=0x0100 in cycle t+1; pbus0_ack_o=1; pbus1_ack_o stays 0; state returns to IDLE.
- Pipelined burst with MAX_OUTST=4: port 0 issues 6 requests, target stall=0 and withholds acks -> 4 accepted, then pbus0_stall_o=1 and outst=4. One ack -> outst=3 and the 5th request is accepted next cycle.
- Contention: both cyc rise in the same cycle -> RR_EN builds GNT0, then GNT1 after port 0 releases (IDLE gap of 1 cycle). Without RR_EN, port 0 repeatedly re-requesting blocks port 1.
- Abort: port 1 owns the bus with outst=2 and drops cyc -> next cycle IDLE and outst=0. A subsequent pbus_ack_i produces no ack on either port.
- Error/retry: owner port 1 receives pbus_err_i, then pbus_rty_i -> pbus1_err_o and pbus1_rty_o pulse once each; outst decrements by 1 each.
- Async reset: assert async_rst_i low mid-burst with outst=3 -> same cycle, pbus_cyc_o=0, both stall_o=1, prb_arb_state_o=0, prb_arb_outst_o=0.
